// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor : bimodal 2-bit-counter predictor, fetch lookup / decode train
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_d,
  input  logic        taken_d,
  output logic        pred_taken_f,
  output logic        pred_taken_d,
  output logic        mispredict_d,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [1:0] C_CTR_RESET = 2'b01;

  logic [1:0]            r_table [ENTRIES];
  logic [INDEX_BITS-1:0] r_idx_d;
  logic                  r_pred_d;
  logic [31:0]           r_branch_cnt;
  logic [31:0]           r_mispredict_cnt;

  logic [INDEX_BITS-1:0] w_idx_f;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_next;
  logic                  w_update;
  logic                  w_pc_unused;

  // Only the index bits of the decode PC are ever consumed, so only they are kept.
  assign w_idx_f     = pc_f[INDEX_BITS+1:2];
  assign w_pc_unused = &{1'b0, pc_f[31:INDEX_BITS+2], pc_f[1:0]};

  assign pred_taken_f   = r_table[w_idx_f][1];
  assign pred_taken_d   = r_pred_d;
  assign mispredict_d   = branch_d & (taken_d != r_pred_d);
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

  // A stalled branch trains once, on the cycle it finally leaves Decode.
  assign w_update  = branch_d & ~stall_d & ~flush_d;
  assign w_ctr_cur = r_table[r_idx_d];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (taken_d) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= C_CTR_RESET;
      r_idx_d          <= '0;
      r_pred_d         <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (flush_d) begin
        r_idx_d  <= '0;
        r_pred_d <= 1'b0;
      end else if (!stall_d) begin
        r_idx_d  <= w_idx_f;
        r_pred_d <= pred_taken_f;
      end
      if (w_update) begin
        r_table[r_idx_d] <= w_ctr_next;
        r_branch_cnt     <= r_branch_cnt + 32'd1;
        if (mispredict_d) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor : directed vector table plus reset sequences
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall_d, flush_d, branch_d, taken_d;
  logic        pred_taken_f, pred_taken_d, mispredict_d;
  logic [31:0] branch_cnt, mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_f           (pc_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .branch_d       (branch_d),
    .taken_d        (taken_d),
    .pred_taken_f   (pred_taken_f),
    .pred_taken_d   (pred_taken_d),
    .mispredict_d   (mispredict_d),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        branch;
    logic        taken;
    logic        e_pf;
    logic        e_pd;
    logic        e_mp;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_reset_state(input string tag);
    int bad = 0;
    branch_d = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pc_f = 32'(i) << 2;
      #1;
      if (pred_taken_f !== 1'b0) bad++;
    end
    check({tag, " sweep pred_f"}, 32'(bad), 32'd0);
    check({tag, " branch_cnt"}, branch_cnt, 32'd0);
    check({tag, " mispredict_cnt"}, mispredict_cnt, 32'd0);
    check({tag, " pred_d"}, {31'd0, pred_taken_d}, 32'd0);
  endtask

  initial begin
    // A = 0x00400010 (idx 4), B = 0x00400014 (idx 5); each row is checked, then clocked.
    //          pc            st fl br tk  pf pd mp  bc  mc
    vecs[0]  = '{32'h00400010, 0, 0, 0, 0,  0, 0, 0,  0,  0};
    vecs[1]  = '{32'h00400014, 0, 0, 1, 1,  0, 0, 1,  0,  0};
    vecs[2]  = '{32'h00400010, 0, 0, 0, 0,  1, 0, 0,  1,  1};
    vecs[3]  = '{32'h00400014, 0, 0, 1, 1,  0, 1, 0,  1,  1};
    vecs[4]  = '{32'h00400010, 0, 0, 0, 0,  1, 0, 0,  2,  1};
    vecs[5]  = '{32'h00400014, 0, 0, 1, 1,  0, 1, 0,  2,  1};
    vecs[6]  = '{32'h00400010, 0, 0, 0, 0,  1, 0, 0,  3,  1};
    // stall four cycles with a not-taken branch predicted taken
    vecs[7]  = '{32'h00400014, 1, 0, 1, 0,  0, 1, 1,  3,  1};
    vecs[8]  = '{32'h00000000, 1, 0, 1, 0,  0, 1, 1,  3,  1};
    vecs[9]  = '{32'h00000000, 1, 0, 1, 0,  0, 1, 1,  3,  1};
    vecs[10] = '{32'h00000000, 1, 0, 1, 0,  0, 1, 1,  3,  1};
    vecs[11] = '{32'h00400014, 0, 0, 1, 0,  0, 1, 1,  3,  1};
    vecs[12] = '{32'h00400010, 0, 0, 0, 0,  1, 0, 0,  4,  2};
    // flush with a branch present
    vecs[13] = '{32'h00400010, 0, 1, 1, 0,  1, 1, 1,  4,  2};
    vecs[14] = '{32'h00400010, 0, 0, 0, 0,  1, 0, 0,  4,  2};
    // walk idx 4 back to 01, then update it while fetching the same index
    vecs[15] = '{32'h00400014, 0, 0, 1, 0,  0, 1, 1,  4,  2};
    vecs[16] = '{32'h00000010, 0, 0, 0, 0,  0, 0, 0,  5,  3};
    vecs[17] = '{32'h00000010, 0, 0, 1, 1,  0, 0, 1,  5,  3};
    vecs[18] = '{32'h00000010, 0, 0, 0, 0,  1, 0, 0,  6,  4};
    vecs[19] = '{32'h00000110, 0, 0, 0, 0,  1, 1, 0,  6,  4};

    rst = 1'b1; pc_f = '0; stall_d = 1'b0; flush_d = 1'b0; branch_d = 1'b0; taken_d = 1'b0;
    tick();
    rst = 1'b0;
    sweep_reset_state("reset");

    for (int i = 0; i < NVEC; i++) begin
      pc_f     = vecs[i].pc;
      stall_d  = vecs[i].stall;
      flush_d  = vecs[i].flush;
      branch_d = vecs[i].branch;
      taken_d  = vecs[i].taken;
      #1;
      check($sformatf("v%0d pred_f", i), {31'd0, pred_taken_f}, {31'd0, vecs[i].e_pf});
      check($sformatf("v%0d pred_d", i), {31'd0, pred_taken_d}, {31'd0, vecs[i].e_pd});
      check($sformatf("v%0d mispredict", i), {31'd0, mispredict_d}, {31'd0, vecs[i].e_mp});
      check($sformatf("v%0d branch_cnt", i), branch_cnt, vecs[i].e_bc);
      check($sformatf("v%0d mispredict_cnt", i), mispredict_cnt, vecs[i].e_mc);
      tick();
    end

    // Train idx 8, 9, 10 to strongly-taken, then reset with a branch pending.
    stall_d = 1'b0; flush_d = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pc_f = 32'h20 + 32'(p * 4);
      branch_d = 1'b1; taken_d = 1'b1;
      for (int k = 0; k < 3; k++) tick();
    end
    branch_d = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pc_f = 32'h20 + 32'(p * 4);
      #1;
      check($sformatf("trained idx%0d pred_f", 8 + p), {31'd0, pred_taken_f}, 32'd1);
    end
    check("pre-reset branch_cnt", branch_cnt, 32'd15);

    pc_f = 32'h28; branch_d = 1'b1; taken_d = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; branch_d = 1'b0; taken_d = 1'b0;
    sweep_reset_state("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
